// File: rtl/golden_nonce_uart_tx_if.sv
// Hit bus and status lines between the control unit, golden_nonce_uart_tx and the board.
// golden_valid is a one-cycle strobe with no ready: a hit offered while the FIFO is full is dropped and latched into overflow.
interface golden_nonce_uart_tx_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  golden_valid;
    logic [31:0]           golden_nonce;
    logic                  uart_tx;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  overflow;
    logic                  busy;
    logic [1:0]            dbg_state;

    modport master (
        output golden_valid, golden_nonce,
        input  uart_tx, fifo_count, overflow, busy, dbg_state
    );

    modport slave (
        input  golden_valid, golden_nonce,
        output uart_tx, fifo_count, overflow, busy, dbg_state
    );
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// Buffers golden nonces in a FIFO and sends each one MSB byte first over an 8N1 UART line.
// Define GOLDEN_NONCE_SYNC_EN to prefix every frame with the 0xA5 sync byte.
module golden_nonce_uart_tx #(
    parameter int DEPTH_LOG2   = 3,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  hash_clk,
    input  logic                  rst_n,
    golden_nonce_uart_tx_if.slave gn_bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TIMER_ONE  = 16'd1;
`ifdef GOLDEN_NONCE_SYNC_EN
    localparam int   BYTE_W  = 3;
    localparam logic SYNC_EN = 1'b1;
`else
    localparam int   BYTE_W  = 2;
    localparam logic SYNC_EN = 1'b0;
`endif
    localparam logic [BYTE_W-1:0]     LAST_BYTE  = BYTE_W'(SYNC_EN ? 4 : 3);
    localparam logic [BYTE_W-1:0]     BYTE_ONE   = BYTE_W'(1);
    localparam logic [2:0]            BIT_ONE    = 3'd1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic [15:0]           r_timer;
    logic [15:0]           w_timer_n;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_n;
    logic [BYTE_W-1:0]     r_byte_idx;
    logic [BYTE_W-1:0]     w_byte_n;
    logic [31:0]           r_shift;
    logic [31:0]           w_shift_n;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_bit_done;
    logic                  w_sync_byte;
    logic [7:0]            w_cur_byte;
    logic                  w_tx;

    // The pop is resolved before the push, so a full FIFO still accepts a hit on a pop cycle.
    assign w_full      = (r_count == FULL_COUNT);
    assign w_push      = gn_bus.golden_valid && (!w_full || w_pop);
    assign w_bit_done  = (r_timer == 16'd0);
    assign w_sync_byte = SYNC_EN && (r_byte_idx == '0);
    assign w_cur_byte  = w_sync_byte ? 8'hA5 : r_shift[31:24];

    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_bit_n   = r_bit_idx;
        w_byte_n  = r_byte_idx;
        w_shift_n = r_shift;
        w_pop     = 1'b0;
        if (r_state != S_IDLE) begin
            w_timer_n = r_timer - TIMER_ONE;
        end
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_state_n = S_START;
                    w_timer_n = BIT_RELOAD;
                    w_shift_n = r_mem[r_rd_ptr];
                    w_byte_n  = '0;
                    w_bit_n   = '0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_n = S_DATA;
                    w_timer_n = BIT_RELOAD;
                    w_bit_n   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_timer_n = BIT_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_n = r_bit_idx + BIT_ONE;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_START;
                        w_timer_n = BIT_RELOAD;
                        w_byte_n  = r_byte_idx + BYTE_ONE;
                        // The sync byte is not held in the shift register, so it must not consume a nonce byte.
                        if (!w_sync_byte) begin
                            w_shift_n = {r_shift[23:0], 8'h00};
                        end
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = w_cur_byte[r_bit_idx];
            default: w_tx = 1'b1;
        endcase
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_timer    <= w_timer_n;
            r_bit_idx  <= w_bit_n;
            r_byte_idx <= w_byte_n;
            r_shift    <= w_shift_n;
        end
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (gn_bus.golden_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the cleared pointers make stale entries unreachable.
    always_ff @(posedge hash_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= gn_bus.golden_nonce;
        end
    end

    assign gn_bus.uart_tx    = w_tx;
    assign gn_bus.busy       = (r_state != S_IDLE);
    assign gn_bus.fifo_count = r_count;
    assign gn_bus.overflow   = r_overflow;
    assign gn_bus.dbg_state  = r_state;
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Self-checking bench for golden_nonce_uart_tx: a line-level UART monitor plus a timing model of the FIFO and frame scheduler.
module tb_golden_nonce_uart_tx;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int CPB        = 4;
`ifdef GOLDEN_NONCE_SYNC_EN
    localparam int BPF = 5;
`else
    localparam int BPF = 4;
`endif
    localparam int BYTE_CYC = 10 * CPB;
    localparam int FRAME    = BPF * BYTE_CYC;

    typedef logic [7:0] byte_q_t[$];

    logic hash_clk = 1'b0;
    logic rst_n    = 1'b0;

    golden_nonce_uart_tx_if #(.DEPTH_LOG2(DEPTH_LOG2)) gn_bus ();

    golden_nonce_uart_tx #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .hash_clk(hash_clk),
        .rst_n   (rst_n),
        .gn_bus  (gn_bus)
    );

    always #5 hash_clk = ~hash_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending nonces and the earliest edge at which the next frame may start.
    int          cyc = 0;
    logic [31:0] m_q[$];
    logic [7:0]  exp_q[$];
    int          m_next_pop = 0;
    int          m_last_pop = -1000000;
    bit          m_ovf  = 1'b0;
    bit          m_busy = 1'b0;

    function automatic byte_q_t frame_of(input logic [31:0] n);
        byte_q_t f;
`ifdef GOLDEN_NONCE_SYNC_EN
        f.push_back(8'hA5);
`endif
        for (int k = 3; k >= 0; k--) f.push_back(n[8*k +: 8]);
        return f;
    endfunction

    initial begin
        byte_q_t f;
        forever begin
            @(posedge hash_clk);
            cyc++;
            if (!rst_n) begin
                m_q.delete();
                exp_q.delete();
                m_ovf      = 1'b0;
                m_next_pop = 0;
                m_last_pop = -1000000;
            end else begin
                if (m_q.size() != 0 && cyc >= m_next_pop) begin
                    f = frame_of(m_q.pop_front());
                    foreach (f[i]) exp_q.push_back(f[i]);
                    m_last_pop = cyc;
                    m_next_pop = cyc + FRAME + 1;
                end
                if (gn_bus.golden_valid) begin
                    if (m_q.size() < DEPTH) m_q.push_back(gn_bus.golden_nonce);
                    else m_ovf = 1'b1;
                end
            end
            m_busy = (cyc - m_last_pop) < FRAME;
        end
    end

    // UART monitor: samples every cycle of a frame, so a bit of the wrong length or level is caught.
    logic [7:0] rx_q[$];
    int         rx_t_q[$];
    bit         mon_active = 1'b0;
    logic       mon_prev   = 1'b1;
    int         mon_err    = 0;

    initial begin
        int   mon_p, mon_t0, b, ph;
        logic [7:0] mon_byte;
        logic tx;
        mon_p = 0; mon_t0 = 0; mon_byte = '0;
        forever begin
            @(negedge hash_clk);
            tx = gn_bus.uart_tx;
            if (!rst_n) begin
                mon_active = 1'b0;
                mon_prev   = 1'b1;
            end else if (!mon_active) begin
                if (mon_prev === 1'b1 && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_p      = 0;
                    mon_t0     = cyc;
                end
                mon_prev = tx;
            end else begin
                mon_p++;
                b  = mon_p / CPB;
                ph = mon_p % CPB;
                if (b == 0 && tx !== 1'b0) mon_err++;
                else if (b >= 1 && b <= 8) begin
                    if (ph == 0) mon_byte[b-1] = tx;
                    else if (tx !== mon_byte[b-1]) mon_err++;
                end else if (b == 9 && tx !== 1'b1) mon_err++;
                if (mon_p == BYTE_CYC - 1) begin
                    rx_q.push_back(mon_byte);
                    rx_t_q.push_back(mon_t0);
                    mon_active = 1'b0;
                end
                mon_prev = tx;
            end
        end
    end

    task automatic do_reset();
        gn_bus.golden_valid = 1'b0;
        gn_bus.golden_nonce = '0;
        @(negedge hash_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge hash_clk);
        rst_n = 1'b1;
        rx_q.delete();
        rx_t_q.delete();
    endtask

    task automatic strobe(input logic [31:0] v);
        @(negedge hash_clk);
        gn_bus.golden_valid = 1'b1;
        gn_bus.golden_nonce = v;
    endtask

    task automatic release_valid();
        @(negedge hash_clk);
        gn_bus.golden_valid = 1'b0;
    endtask

    // Runs until model and line are both quiet, tallying cycles where the status outputs disagree with the model.
    task automatic wait_drain(input int budget, output bit ok, output int mism, output int busy_cyc, output string msg);
        ok = 1'b0; mism = 0; busy_cyc = 0; msg = "none";
        for (int i = 0; i < budget; i++) begin
            @(negedge hash_clk);
            if (gn_bus.busy === 1'b1) busy_cyc++;
            if (gn_bus.fifo_count !== 3'(m_q.size()) || gn_bus.busy !== m_busy || gn_bus.overflow !== m_ovf ||
                (!m_busy && gn_bus.uart_tx !== 1'b1)) begin
                if (mism == 0)
                    msg = $sformatf("cycle %0d count=%0d/%0d busy=%0b/%0b ovf=%0b/%0b tx=%0b", cyc, gn_bus.fifo_count,
                                    m_q.size(), gn_bus.busy, m_busy, gn_bus.overflow, m_ovf, gn_bus.uart_tx);
                mism++;
            end
            if (m_q.size() == 0 && !m_busy && !mon_active && gn_bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        gn_bus.golden_valid = 1'b1;
        gn_bus.golden_nonce = 32'hFFFF_0000;
        rst_n = 1'b0;
        @(negedge hash_clk);
        #1;
        checks++;
        if (gn_bus.uart_tx !== 1'b1 || gn_bus.busy !== 1'b0 || gn_bus.overflow !== 1'b0 || gn_bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL in_reset: tx=%0b busy=%0b ovf=%0b count=%0d, required 1 0 0 0", gn_bus.uart_tx, gn_bus.busy,
                     gn_bus.overflow, gn_bus.fifo_count);
        end
        @(negedge hash_clk);
        gn_bus.golden_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge hash_clk);
            checks++;
            if (gn_bus.uart_tx !== 1'b1 || gn_bus.busy !== 1'b0 || gn_bus.overflow !== 1'b0 || gn_bus.fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: tx=%0b busy=%0b ovf=%0b count=%0d, required 1 0 0 0", i, gn_bus.uart_tx,
                         gn_bus.busy, gn_bus.overflow, gn_bus.fifo_count);
            end
        end
    endtask

    task automatic test_single();
        byte_q_t want;
        bit ok; int mism, busy_cyc, bad; string msg;
        do_reset();
        strobe(32'h1234_5678);
        release_valid();
        checks++;
        if (gn_bus.fifo_count !== 3'd1 || gn_bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_push: count=%0d busy=%0b, required 1 0", gn_bus.fifo_count, gn_bus.busy);
        end
        @(negedge hash_clk);
        checks++;
        if (gn_bus.fifo_count !== 3'd0 || gn_bus.busy !== 1'b1 || gn_bus.uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: count=%0d busy=%0b tx=%0b, required 0 1 0", gn_bus.fifo_count, gn_bus.busy, gn_bus.uart_tx);
        end
        wait_drain(FRAME + 100, ok, mism, busy_cyc, msg);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: line not idle, required idle within %0d", FRAME + 100); end
        checks++;
        if (mism !== 0) begin errors++; $display("FAIL single_status: %0d bad cycles, first %s, required 0", mism, msg); end
        checks++;
        if (busy_cyc + 1 !== FRAME) begin errors++; $display("FAIL single_frame_len: %0d, required %0d", busy_cyc + 1, FRAME); end
        want = frame_of(32'h1234_5678);
        bad = (rx_q.size() == want.size()) ? -1 : 999;
        for (int i = 0; i < want.size() && bad < 0; i++) if (rx_q[i] !== want[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL single_bytes: got %p, required %p", rx_q, want); end
        checks++;
        if (rx_t_q.size() !== BPF || rx_t_q[rx_t_q.size()-1] - rx_t_q[0] !== (BPF - 1) * BYTE_CYC) begin
            errors++;
            $display("FAIL single_byte_spacing: starts %p, required %0d bytes %0d apart", rx_t_q, BPF, BYTE_CYC);
        end
    endtask

    task automatic test_burst();
        byte_q_t want, f;
        bit ok; int mism, busy_cyc, bad, step;
        string msg;
        do_reset();
        for (int v = 1; v <= 6; v++) strobe(32'(v));
        release_valid();
        checks++;
        if (gn_bus.fifo_count !== 3'd4 || gn_bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_full: count=%0d ovf=%0b, required 4 1", gn_bus.fifo_count, gn_bus.overflow);
        end
        wait_drain(6 * (FRAME + 1) + 100, ok, mism, busy_cyc, msg);
        checks++;
        if (!ok || mism !== 0) begin errors++; $display("FAIL burst_status: ok=%0b bad=%0d first %s, required ok=1 bad=0", ok, mism, msg); end
        for (int v = 1; v <= 5; v++) begin f = frame_of(32'(v)); foreach (f[i]) want.push_back(f[i]); end
        bad = (rx_q.size() == want.size()) ? -1 : 999;
        for (int i = 0; i < want.size() && bad < 0; i++) if (rx_q[i] !== want[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL burst_bytes: got %p, required %p", rx_q, want); end
        bad = (rx_t_q.size() == 5 * BPF) ? -1 : 999;
        for (int i = 1; i < rx_t_q.size() && bad < 0; i++) begin
            step = (i % BPF == 0) ? BYTE_CYC + 1 : BYTE_CYC;
            if (rx_t_q[i] - rx_t_q[i-1] !== step) bad = i;
        end
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL burst_gap: byte starts %p, required %0d within frame and +1 between", rx_t_q, BYTE_CYC); end
        checks++;
        if (gn_bus.overflow !== 1'b1) begin errors++; $display("FAIL burst_sticky: ovf=%0b, required 1", gn_bus.overflow); end
    endtask

    task automatic test_push_on_pop();
        byte_q_t want, f;
        bit ok; int mism, busy_cyc, bad;
        string msg;
        do_reset();
        for (int v = 1; v <= 5; v++) strobe(32'(v));
        release_valid();
        for (int i = 0; i < FRAME + 50 && cyc + 1 != m_next_pop; i++) @(negedge hash_clk);
        checks++;
        if (cyc + 1 !== m_next_pop) begin errors++; $display("FAIL pop_align: cycle %0d, required %0d", cyc + 1, m_next_pop); end
        gn_bus.golden_valid = 1'b1;
        gn_bus.golden_nonce = 32'h0000_0077;
        release_valid();
        checks++;
        if (gn_bus.fifo_count !== 3'd4 || gn_bus.overflow !== 1'b0 || gn_bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL push_on_pop: count=%0d ovf=%0b busy=%0b, required 4 0 1", gn_bus.fifo_count, gn_bus.overflow, gn_bus.busy);
        end
        wait_drain(6 * (FRAME + 1) + 100, ok, mism, busy_cyc, msg);
        checks++;
        if (!ok || mism !== 0) begin errors++; $display("FAIL pop_push_status: ok=%0b bad=%0d first %s, required ok=1 bad=0", ok, mism, msg); end
        for (int v = 1; v <= 5; v++) begin f = frame_of(32'(v)); foreach (f[i]) want.push_back(f[i]); end
        f = frame_of(32'h0000_0077);
        foreach (f[i]) want.push_back(f[i]);
        bad = (rx_q.size() == want.size()) ? -1 : 999;
        for (int i = 0; i < want.size() && bad < 0; i++) if (rx_q[i] !== want[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL pop_push_bytes: got %p, required %p", rx_q, want); end
        checks++;
        if (gn_bus.overflow !== 1'b0) begin errors++; $display("FAIL pop_push_ovf: ovf=%0b, required 0", gn_bus.overflow); end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t want;
        bit ok; int mism, busy_cyc, bad, target;
        string msg;
        do_reset();
        strobe(32'h1234_5678);
        strobe(32'hCAFE_F00D);
        release_valid();
        target = m_last_pop + BYTE_CYC + CPB + 1;
        for (int i = 0; i < 2 * BYTE_CYC && cyc < target; i++) @(negedge hash_clk);
        checks++;
        if (gn_bus.uart_tx !== 1'b0 || gn_bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset: tx=%0b count=%0d, required 0 1", gn_bus.uart_tx, gn_bus.fifo_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gn_bus.uart_tx !== 1'b1 || gn_bus.fifo_count !== 3'd0 || gn_bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx=%0b count=%0d busy=%0b, required 1 0 0", gn_bus.uart_tx, gn_bus.fifo_count, gn_bus.busy);
        end
        repeat (2) @(negedge hash_clk);
        rst_n = 1'b1;
        rx_q.delete();
        rx_t_q.delete();
        strobe(32'hDEAD_BEEF);
        release_valid();
        wait_drain(2 * FRAME + 100, ok, mism, busy_cyc, msg);
        checks++;
        if (!ok || mism !== 0) begin errors++; $display("FAIL after_reset_status: ok=%0b bad=%0d first %s, required ok=1 bad=0", ok, mism, msg); end
        want = frame_of(32'hDEAD_BEEF);
        bad = (rx_q.size() == want.size()) ? -1 : 999;
        for (int i = 0; i < want.size() && bad < 0; i++) if (rx_q[i] !== want[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL after_reset_bytes: got %p, required %p", rx_q, want); end
    endtask

    task automatic test_wrap();
        byte_q_t want, f;
        bit ok; int mism, busy_cyc, bad;
        logic [31:0] v;
        string msg;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            v = $urandom;
            f = frame_of(v);
            foreach (f[i]) want.push_back(f[i]);
            strobe(v);
            release_valid();
            repeat (168) @(negedge hash_clk);
        end
        wait_drain(4 * (FRAME + 1) + 100, ok, mism, busy_cyc, msg);
        checks++;
        if (!ok || mism !== 0) begin errors++; $display("FAIL wrap_status: ok=%0b bad=%0d first %s, required ok=1 bad=0", ok, mism, msg); end
        bad = (rx_q.size() == want.size()) ? -1 : 999;
        for (int i = 0; i < want.size() && bad < 0; i++) if (rx_q[i] !== want[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL wrap_bytes: first bad index %0d, got %0d bytes, required %0d", bad, rx_q.size(), want.size()); end
        checks++;
        if (gn_bus.overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: ovf=%0b, required 0", gn_bus.overflow); end
    endtask

    task automatic test_random();
        bit ok; int mism, busy_cyc, bad, gap;
        string msg;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            strobe($urandom);
            gap = $urandom_range(0, 60);
            if (gap > 0) begin
                release_valid();
                repeat (gap - 1) @(negedge hash_clk);
            end
        end
        release_valid();
        wait_drain((DEPTH + 2) * (FRAME + 1) + 100, ok, mism, busy_cyc, msg);
        checks++;
        if (!ok || mism !== 0) begin errors++; $display("FAIL random_status: ok=%0b bad=%0d first %s, required ok=1 bad=0", ok, mism, msg); end
        bad = (rx_q.size() == exp_q.size()) ? -1 : 999;
        for (int i = 0; i < exp_q.size() && bad < 0; i++) if (rx_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL random_bytes: first bad index %0d, got %0d bytes, required %0d", bad, rx_q.size(), exp_q.size()); end
        checks++;
        if (gn_bus.overflow !== m_ovf) begin errors++; $display("FAIL random_ovf: ovf=%0b, required %0b", gn_bus.overflow, m_ovf); end
        checks++;
        if (mon_err !== 0) begin errors++; $display("FAIL line_framing: %0d bad bit samples, required 0", mon_err); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        gn_bus.golden_valid = 1'b0;
        gn_bus.golden_nonce = '0;
        test_reset();
        test_single();
        test_burst();
        test_push_on_pop();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
